// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer: selects the next PC, runs the
// variable-latency imem handshake, squashes wrong-path fetches and traps misaligned targets.
module pc_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      PCSrc,
  input  logic            resolve_valid,
  input  logic [XLEN-1:0] PCTarget,
  input  logic [XLEN-1:0] ALUResult,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  output logic            instr_valid,
  output logic [31:0]     Instr,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic            fetch_fault
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);
  localparam logic [31:0]     NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10,
    FAULT = 2'b11
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [XLEN-1:0] fetch_pc_r, fetch_pc_nxt_s;
  logic [XLEN-1:0] redir_pc_r, redir_pc_nxt_s;
  logic            kill_r, kill_nxt_s;
  logic            req_nxt_s, valid_nxt_s, fault_nxt_s;
  logic [XLEN-1:0] addr_nxt_s, pc_nxt_s, pcp4_nxt_s;
  logic [31:0]     instr_nxt_s;
  logic [XLEN-1:0] target_s;
  logic            redirect_s;
  logic            misaligned_s;

  assign redirect_s   = resolve_valid && (PCSrc != 2'b00);
  assign misaligned_s = (target_s[1:0] != 2'b00);

  // Redirect target: jalr targets have their LSB cleared.
  always_comb begin
    target_s = PCTarget;
    if (PCSrc == 2'b01) begin
      target_s = PCTarget;
    end else begin
      target_s = {ALUResult[XLEN-1:1], 1'b0};
    end
  end

  // Next-state and next-output computation.
  always_comb begin
    state_nxt_s    = state_r;
    fetch_pc_nxt_s = fetch_pc_r;
    redir_pc_nxt_s = redir_pc_r;
    kill_nxt_s     = kill_r;
    req_nxt_s      = imem_req;
    addr_nxt_s     = imem_addr;
    instr_nxt_s    = Instr;
    pc_nxt_s       = PC;
    pcp4_nxt_s     = PCPlus4;
    fault_nxt_s    = fetch_fault;
    valid_nxt_s    = instr_valid;

    if (instr_valid && !stall) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = instr_valid;
    end

    case (state_r)
      BOOT: begin
        state_nxt_s = FETCH;
        req_nxt_s   = 1'b1;
        addr_nxt_s  = fetch_pc_r;
      end
      FETCH: begin
        if (imem_ready && kill_r) begin
          // Wrong-path data returns: drop it and move to the pending target.
          kill_nxt_s     = 1'b0;
          fetch_pc_nxt_s = redir_pc_r;
          addr_nxt_s     = redir_pc_r;
          req_nxt_s      = 1'b1;
        end else if (imem_ready) begin
          instr_nxt_s    = imem_rdata;
          pc_nxt_s       = fetch_pc_r;
          pcp4_nxt_s     = fetch_pc_r + PC_STEP;
          valid_nxt_s    = 1'b1;
          fetch_pc_nxt_s = fetch_pc_r + PC_STEP;
          if (!stall) begin
            addr_nxt_s = fetch_pc_r + PC_STEP;
            req_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = HOLD;
            req_nxt_s   = 1'b0;
          end
        end else begin
          req_nxt_s = 1'b1;
        end
      end
      HOLD: begin
        if (!stall) begin
          state_nxt_s = FETCH;
          req_nxt_s   = 1'b1;
          addr_nxt_s  = fetch_pc_r;
        end else begin
          req_nxt_s = 1'b0;
        end
      end
      FAULT: begin
        req_nxt_s   = 1'b0;
        valid_nxt_s = 1'b0;
        fault_nxt_s = 1'b1;
        kill_nxt_s  = 1'b0;
      end
      default: begin
        state_nxt_s = FAULT;
        req_nxt_s   = 1'b0;
        valid_nxt_s = 1'b0;
        fault_nxt_s = 1'b1;
      end
    endcase

    // A redirect overrides stall and any sequential progress made above.
    if (redirect_s && (state_r != FAULT)) begin
      valid_nxt_s = 1'b0;
      instr_nxt_s = Instr;
      pc_nxt_s    = PC;
      pcp4_nxt_s  = PCPlus4;
      if (misaligned_s) begin
        state_nxt_s = FAULT;
        req_nxt_s   = 1'b0;
        fault_nxt_s = 1'b1;
        kill_nxt_s  = 1'b0;
      end else if ((state_r == FETCH) && !imem_ready) begin
        kill_nxt_s     = 1'b1;
        redir_pc_nxt_s = target_s;
        fetch_pc_nxt_s = fetch_pc_r;
        addr_nxt_s     = imem_addr;
        req_nxt_s      = 1'b1;
        state_nxt_s    = FETCH;
      end else begin
        kill_nxt_s     = 1'b0;
        fetch_pc_nxt_s = target_s;
        addr_nxt_s     = target_s;
        req_nxt_s      = 1'b1;
        state_nxt_s    = FETCH;
      end
    end else begin
      valid_nxt_s = valid_nxt_s;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= BOOT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Fetch bookkeeping and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_r  <= RESET_PC;
      redir_pc_r  <= RESET_PC;
      kill_r      <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      Instr       <= NOP;
      PC          <= RESET_PC;
      PCPlus4     <= RESET_PC + PC_STEP;
      fetch_fault <= 1'b0;
    end else begin
      fetch_pc_r  <= fetch_pc_nxt_s;
      redir_pc_r  <= redir_pc_nxt_s;
      kill_r      <= kill_nxt_s;
      imem_req    <= req_nxt_s;
      imem_addr   <= addr_nxt_s;
      instr_valid <= valid_nxt_s;
      Instr       <= instr_nxt_s;
      PC          <= pc_nxt_s;
      PCPlus4     <= pcp4_nxt_s;
      fetch_fault <= fault_nxt_s;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a vector table walks sequential fetch, late imem,
// kill/redirect, stall and wrap; hand sequences cover async reset and the misalign trap.
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic [1:0]  PCSrc;
  logic        resolve_valid;
  logic [31:0] PCTarget;
  logic [31:0] ALUResult;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        instr_valid;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        fetch_fault;

  int checks;
  int failures;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .resolve_valid(resolve_valid),
    .PCTarget(PCTarget), .ALUResult(ALUResult), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .instr_valid(instr_valid), .Instr(Instr), .PC(PC),
    .PCPlus4(PCPlus4), .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  // Instruction memory returns an address-tagged word whenever it is ready.
  assign imem_rdata = mem_word(imem_addr);

  typedef struct {
    logic        rv;
    logic [1:0]  src;
    logic [31:0] tgt;
    logic [31:0] alu;
    logic        rdy;
    logic        stl;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pc;
    logic [31:0] e_pcp4;
    logic        e_flt;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req},    32'd0);
    chk({tag, "_addr"},  imem_addr,            32'h0000_0000);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_instr"}, Instr,                32'h0000_0013);
    chk({tag, "_pc"},    PC,                   32'h0000_0000);
    chk({tag, "_pcp4"},  PCPlus4,              32'h0000_0004);
    chk({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
  endtask

  task automatic drive(input logic rv, input logic [1:0] src, input logic [31:0] tgt,
                       input logic [31:0] alu, input logic rdy, input logic stl);
    resolve_valid = rv;
    PCSrc         = src;
    PCTarget      = tgt;
    ALUResult     = alu;
    imem_ready    = rdy;
    stall         = stl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);

    // rv src tgt alu rdy stl | req addr valid pc pcp4 fault
    vq.push_back('{1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0004, 1'b0});
    vq.push_back('{1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000, 32'h0000_0004, 1'b0});
    vq.push_back('{1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004, 32'h0000_0008, 1'b0});
    for (int i = 0; i < 3; i++)
      vq.push_back('{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0008, 1'b0, 32'h0000_0004, 32'h0000_0008, 1'b0});
    vq.push_back('{1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008, 32'h0000_000C, 1'b0});
    vq.push_back('{1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C, 32'h0000_0010, 1'b0});
    // branch to 0x100 while 0x10 is outstanding
    vq.push_back('{1'b1, 2'b01, 32'h100, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'h0000_000C, 32'h0000_0010, 1'b0});
    vq.push_back('{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'h0000_000C, 32'h0000_0010, 1'b0});
    vq.push_back('{1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_000C, 32'h0000_0010, 1'b0});
    vq.push_back('{1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100, 32'h0000_0104, 1'b0});
    vq.push_back('{1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0108, 1'b1, 32'h0000_0104, 32'h0000_0108, 1'b0});
    // redirect coinciding with imem_ready, then stall over the 0x20 word
    vq.push_back('{1'b1, 2'b01, 32'h20, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0020, 1'b0, 32'h0000_0104, 32'h0000_0108, 1'b0});
    vq.push_back('{1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 1'b1, 32'h0000_0020, 32'h0000_0024, 1'b0});
    for (int i = 0; i < 3; i++)
      vq.push_back('{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0000_0020, 1'b1, 32'h0000_0020, 32'h0000_0024, 1'b0});
    vq.push_back('{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0024, 1'b0, 32'h0000_0020, 32'h0000_0024, 1'b0});
    vq.push_back('{1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0028, 1'b1, 32'h0000_0024, 32'h0000_0028, 1'b0});
    // jalr to 0x301&~1, overwritten by branch to 0x400, then a PCSrc=00 no-op
    vq.push_back('{1'b1, 2'b10, 32'h0, 32'h301, 1'b0, 1'b0, 1'b1, 32'h0000_0028, 1'b0, 32'h0000_0024, 32'h0000_0028, 1'b0});
    vq.push_back('{1'b1, 2'b01, 32'h400, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0028, 1'b0, 32'h0000_0024, 32'h0000_0028, 1'b0});
    vq.push_back('{1'b1, 2'b00, 32'h500, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0028, 1'b0, 32'h0000_0024, 32'h0000_0028, 1'b0});
    vq.push_back('{1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0400, 1'b0, 32'h0000_0024, 32'h0000_0028, 1'b0});
    vq.push_back('{1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0404, 1'b1, 32'h0000_0400, 32'h0000_0404, 1'b0});
    // wrap at the top of the address space
    vq.push_back('{1'b1, 2'b01, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0400, 32'h0000_0404, 1'b0});
    vq.push_back('{1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0});
    vq.push_back('{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0});

    tick();
    tick();
    chk_reset_vals("rst");
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rv, vq[i].src, vq[i].tgt, vq[i].alu, vq[i].rdy, vq[i].stl);
      tick();
      chk($sformatf("v%0d_req", i),   {31'd0, imem_req},    {31'd0, vq[i].e_req});
      chk($sformatf("v%0d_addr", i),  imem_addr,            vq[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'd0, instr_valid}, {31'd0, vq[i].e_val});
      chk($sformatf("v%0d_pc", i),    PC,                   vq[i].e_pc);
      chk($sformatf("v%0d_pcp4", i),  PCPlus4,              vq[i].e_pcp4);
      chk($sformatf("v%0d_fault", i), {31'd0, fetch_fault}, {31'd0, vq[i].e_flt});
      if (vq[i].e_val) begin
        chk($sformatf("v%0d_instr", i), Instr, mem_word(vq[i].e_pc));
      end else begin
        chk($sformatf("v%0d_noinstr_req_hold", i), {31'd0, imem_req}, {31'd0, vq[i].e_req});
      end
    end

    // Asynchronous reset while a request to 0x0 is outstanding.
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    tick();
    reset = 1'b0;

    // Misaligned jalr target traps and stays trapped while imem drains.
    tick();
    chk("boot_req",  {31'd0, imem_req}, 32'd1);
    chk("boot_addr", imem_addr,         32'h0000_0000);
    drive(1'b1, 2'b11, 32'h0, 32'h203, 1'b0, 1'b0);
    tick();
    chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
    chk("mis_req",   {31'd0, imem_req},    32'd0);
    chk("mis_valid", {31'd0, instr_valid}, 32'd0);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("flt%0d_fault", k), {31'd0, fetch_fault}, 32'd1);
      chk($sformatf("flt%0d_req", k),   {31'd0, imem_req},    32'd0);
      chk($sformatf("flt%0d_valid", k), {31'd0, instr_valid}, 32'd0);
    end
    drive(1'b1, 2'b01, 32'h40, 32'h0, 1'b1, 1'b0);
    tick();
    chk("flt_redir_req", {31'd0, imem_req}, 32'd0);
    reset = 1'b1;
    #1;
    chk_reset_vals("flt_rst");
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
